uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver top level: the receive-side counterpart of the wave generator's UART transmitter.
- Synchronises the serial input and generates its own 16x oversample enable.
- Decodes 8N1 frames, LSB first, and buffers received bytes in an internal first-word-fall-through (FWFT) FIFO.
- Downstream logic pops bytes with a read enable.
- Self-contained: baud generator, receive FSM and FIFO are all internal.

Parameters:
- BAUD_RATE, 57_600: serial bit rate.
- CLOCK_RATE, 50_000_000: clk_rx frequency in Hz.
- FIFO_DEPTH, 16: receive FIFO entries; power of two, minimum 2.

Ports:
- clk_rx  input  1  system clock.
- rst_n_clk_rx  input  1  asynchronous reset, active low.
- rxd_rx  input  1  serial receive line, asynchronous, idle high.
- rx_dout  output  8  head of FIFO (FWFT).
- read_en  input  1  pop head of FIFO.
- rx_fifo_empty  output  1  FIFO holds no bytes.
- rx_fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
- frm_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: valid byte dropped because FIFO full.

Behaviour:
Clock and reset
- One clock, clk_rx.
- rst_n_clk_rx is asynchronous and active low; all flops clear immediately on assertion. Deassertion is synchronous to clk_rx at the system level.

Reset values
- rx_dout=8'h00, rx_fifo_empty=1, rx_fifo_full=0, frm_err=0, overrun=0.
- FSM=IDLE; all counters and pointers 0; shift register 0.
- FIFO storage cleared to 0; synchroniser flops reset to 1.

Input synchroniser
- rxd_rx passes through 2 flops to give rxd_s; the synchroniser adds 2 cycles of latency.

Baud generator
- DIV = round(CLOCK_RATE / (16*BAUD_RATE)); default 54.
- Free-running counter 0..DIV-1; baud_x16_en is high for one cycle when count == DIV-1.
- The counter is never restarted by frame activity.

Receive FSM
- Advances only on baud_x16_en cycles; uses a 4-bit oversample counter (os_cnt) and a 3-bit bit index.
- IDLE: rxd_s==0 -> START, os_cnt=0.
- START: os_cnt increments. At os_cnt==7 (mid start bit):
  - rxd_s==0 -> DATA, os_cnt=0, bit index=0.
  - rxd_s==1 -> IDLE (glitch rejected; no error reported).
- DATA: os_cnt increments; at os_cnt==15, sample rxd_s into the shift register, LSB first, and os_cnt wraps to 0. After bit 7 -> STOP.
- STOP: sample at os_cnt==15.
  - rxd_s==1 and FIFO not full: push byte -> IDLE.
  - rxd_s==1 and FIFO full: byte discarded, overrun=1 for one clk_rx cycle -> IDLE.
  - rxd_s==0: byte discarded, frm_err=1 for one clk_rx cycle -> BREAK.
- BREAK: stay until rxd_s==1 on an enable cycle -> IDLE. This prevents a held-low line from producing repeated frames.

FIFO
- Read and write pointers of log2(FIFO_DEPTH) bits, wrapping naturally, plus an occupancy count of log2(FIFO_DEPTH)+1 bits.
- Write happens on the push cycle; the byte is visible on rx_dout and rx_fifo_empty falls on the next clk_rx edge.
- rx_dout = mem[rd_ptr], combinational from registered state; valid whenever rx_fifo_empty=0.
- read_en while empty: ignored, pointers unchanged.
- Simultaneous push and read_en, including when full: both occur and the count is unchanged.
- A push that coincides with read_en while full is accepted; overrun is not flagged.
- rx_fifo_full and rx_fifo_empty are decoded from the count, which is registered.

Latency
- Frame start edge on rxd_rx to byte visible: about 9.5 bit times plus 3 clk_rx cycles.

Reset mid-frame
- The partial byte is lost and FIFO contents are cleared.
- After deassertion the FSM is in IDLE and resynchronises on the next falling edge.

Test Plan:
1. Reset and idle: assert rst_n_clk_rx=0, then release; hold rxd_rx=1 for 10000 cycles -> rx_fifo_empty=1, rx_fifo_full=0, rx_dout=8'h00, frm_err and overrun never pulse.
2. Single byte: bench serialiser at 864 clk/bit sends 8'hA5 -> rx_fifo_empty falls, rx_dout=8'hA5. Pulse read_en for 1 cycle -> rx_fifo_empty=1 next cycle. Repeat with 8'h00, 8'hFF and back-to-back 8'h01/8'h80 -> bytes received in order.
3. Glitch: rxd_rx low for 200 clk, then high -> no byte, no frm_err; a following 8'h5A is received correctly.
4. Framing error: send 8'h3C with stop bit 0 and hold rxd_rx low 3 bit times -> exactly one frm_err pulse, FIFO stays empty. Release line, then send 8'h55 -> received.
5. Overrun: send 8'h00..8'h10 (17 bytes) with no reads -> rx_fifo_full=1 after the 16th byte, one overrun pulse on the 17th. 16 reads return 8'h00..8'h0F, after which rx_fifo_empty=1. A read_en on empty changes nothing.
6. Reset mid-frame: assert reset during data bit 4 of 8'hC3 with one byte already queued -> all outputs return to reset values immediately. A subsequent 8'h96 is received as the only byte.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver. It accepts 8N1 frames, LSB first, and buffers each received
// byte in an internal first-word-fall-through FIFO. The receiver contains a
// two-flop input synchroniser, a free-running 16x oversample enable, the
// receive FSM and the FIFO.
//
// Ports
//   clk_rx         in   system clock
//   rst_n_clk_rx   in   asynchronous reset, active low
//   rxd_rx         in   serial receive line (asynchronous, idle high)
//   rx_dout        out  [7:0] head of FIFO, valid while rx_fifo_empty=0
//   read_en        in   pop the head of the FIFO (ignored when empty)
//   rx_fifo_empty  out  FIFO holds no bytes
//   rx_fifo_full   out  FIFO holds FIFO_DEPTH bytes
//   frm_err        out  one-cycle pulse: stop bit sampled low
//   overrun        out  one-cycle pulse: good byte dropped, FIFO full
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_RATE  = 57_600,
    parameter int CLOCK_RATE = 50_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_rx,
    input  logic       rst_n_clk_rx,
    input  logic       rxd_rx,
    output logic [7:0] rx_dout,
    input  logic       read_en,
    output logic       rx_fifo_empty,
    output logic       rx_fifo_full,
    output logic       frm_err,
    output logic       overrun
);

    // Round-to-nearest divider for the 16x oversample enable.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

    localparam int DIV    = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BAUD_W-1:0] DIV_LAST = BAUD_W'(DIV - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic              rxd_meta_q, rxd_s_q;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic              baud_x16_en;
    logic [2:0]        state_q, state_d;
    logic [3:0]        os_cnt_q, os_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_done;
    logic              frm_err_q, frm_err_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    // Synchroniser flops reset to the idle-high line level so that reset
    // release never looks like a start edge.
    always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
        if (!rst_n_clk_rx) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_rx;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Free-running oversample divider; frame activity never restarts it, so
    // the start-edge detection jitter is at most one enable period.
    assign baud_x16_en = (baud_cnt_q == DIV_LAST);

    always_comb begin
        baud_cnt_d = baud_x16_en ? '0 : baud_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frm_err_d = 1'b0;
        if (baud_x16_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (os_cnt_q == 4'd7) begin
                        if (!rxd_s_q) begin
                            state_d   = S_DATA;
                            os_cnt_d  = '0;
                            bit_idx_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    // os_cnt wraps 15 -> 0 naturally; sample lands mid-bit.
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        shift_d   = {rxd_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        if (rxd_s_q) begin
                            byte_done = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            frm_err_d = 1'b1;
                            state_d   = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // cannot produce a stream of bogus frames.
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when read_en is high.
    always_comb begin
        do_pop    = read_en && (count_q != '0);
        do_push   = byte_done && ((count_q != FULL_CNT) || do_pop);
        overrun_d = byte_done && !do_push;
        mem_d     = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
        end
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
        if (!rst_n_clk_rx) begin
            baud_cnt_q <= '0;
            state_q    <= S_IDLE;
            os_cnt_q   <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            frm_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            baud_cnt_q <= baud_cnt_d;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            frm_err_q  <= frm_err_d;
            overrun_q  <= overrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rx_dout       = mem_q[rd_ptr_q];
    assign rx_fifo_empty = (count_q == '0);
    assign rx_fifo_full  = (count_q == FULL_CNT);
    assign frm_err       = frm_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx. The clock/baud ratio is scaled down (divider 4, i.e.
// 64 clocks per bit) so the whole run stays short; the receiver logic is the
// same as at the default rate.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 25_000;
    localparam int DIV    = 4;
    localparam int BIT    = 16 * DIV;
    localparam int DEPTH  = 16;

    logic       clk_rx = 1'b0;
    logic       rst_n_clk_rx;
    logic       rxd_rx;
    logic       read_en;
    logic [7:0] rx_dout;
    logic       rx_fifo_empty, rx_fifo_full, frm_err, overrun;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        logic       drain;
        int         exp_frm;
    } vec_t;

    vec_t vecs [7];

    uart_rx #(
        .BAUD_RATE (BAUD),
        .CLOCK_RATE(CLK_HZ),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_rx       (clk_rx),
        .rst_n_clk_rx (rst_n_clk_rx),
        .rxd_rx       (rxd_rx),
        .rx_dout      (rx_dout),
        .read_en      (read_en),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_full (rx_fifo_full),
        .frm_err      (frm_err),
        .overrun      (overrun)
    );

    always #10 clk_rx = ~clk_rx;

    always @(negedge clk_rx) begin
        if (frm_err) frm_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd_rx = b;
        repeat (BIT) @(posedge clk_rx);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rxd_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rxd_rx = 1'b1;
        repeat (n) @(posedge clk_rx);
    endtask

    // Pop every expected byte, in order, then confirm the FIFO is empty.
    task automatic drain(input string name);
        logic [7:0] e;
        int t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = 0;
            @(negedge clk_rx);
            while (rx_fifo_empty && t < 30 * BIT) begin
                @(negedge clk_rx);
                t++;
            end
            check({name, "_avail"}, {31'd0, rx_fifo_empty}, 32'd0);
            check({name, "_data"}, {24'd0, rx_dout}, {24'd0, e});
            read_en = 1'b1;
            @(posedge clk_rx);
            #1 read_en = 1'b0;
        end
        @(negedge clk_rx);
        check({name, "_empty"}, {31'd0, rx_fifo_empty}, 32'd1);
    endtask

    initial begin
        int frm0;
        int ovr0;
        rst_n_clk_rx = 1'b0;
        rxd_rx       = 1'b1;
        read_en      = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 0, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1'b1, 0};
        vecs[3] = '{8'h01, 1'b1, 0, 1'b0, 0};
        vecs[4] = '{8'h80, 1'b1, 0, 1'b1, 0};
        vecs[5] = '{8'h3C, 1'b0, 3, 1'b1, 1};
        vecs[6] = '{8'h55, 1'b1, 0, 1'b1, 0};

        // Reset and idle
        #5;
        check("rst_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check("rst_full", {31'd0, rx_fifo_full}, 32'd0);
        check("rst_dout", {24'd0, rx_dout}, 32'h00);
        check("rst_frm", {31'd0, frm_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        repeat (3) @(posedge clk_rx);
        #1 rst_n_clk_rx = 1'b1;
        idle(10000);
        @(negedge clk_rx);
        check("idle_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check("idle_full", {31'd0, rx_fifo_full}, 32'd0);
        check("idle_dout", {24'd0, rx_dout}, 32'h00);
        check("idle_pulses", frm_cnt + ovr_cnt, 32'd0);

        // Table-driven frames: normal bytes, back-to-back pair, framing error
        for (int v = 0; v < 7; v++) begin
            frm0 = frm_cnt;
            ovr0 = ovr_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            if (vecs[v].stop) exp_q.push_back(vecs[v].data);
            if (vecs[v].low_bits > 0) begin
                rxd_rx = 1'b0;
                repeat (vecs[v].low_bits * BIT) @(posedge clk_rx);
                idle(2 * BIT);
            end
            idle(20);
            @(negedge clk_rx);
            check($sformatf("vec%0d_frm", v), frm_cnt - frm0, vecs[v].exp_frm);
            check($sformatf("vec%0d_ovr", v), ovr_cnt - ovr0, 32'd0);
            if (vecs[v].drain) drain($sformatf("vec%0d", v));
        end

        // Glitch shorter than half a bit: rejected without an error
        frm0 = frm_cnt;
        rxd_rx = 1'b0;
        repeat (BIT / 4) @(posedge clk_rx);
        idle(3 * BIT);
        @(negedge clk_rx);
        check("glitch_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check("glitch_frm", frm_cnt - frm0, 32'd0);
        send_frame(8'h5A, 1'b1);
        exp_q.push_back(8'h5A);
        idle(20);
        drain("glitch_5a");

        // Overrun: 17 bytes with no reads
        ovr0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i < DEPTH) exp_q.push_back(8'(i));
            if (i == 15) begin
                idle(20);
                @(negedge clk_rx);
                check("ovr_full16", {31'd0, rx_fifo_full}, 32'd1);
                check("ovr_none16", ovr_cnt - ovr0, 32'd0);
            end
        end
        idle(20);
        @(negedge clk_rx);
        check("ovr_pulse", ovr_cnt - ovr0, 32'd1);
        check("ovr_full17", {31'd0, rx_fifo_full}, 32'd1);
        drain("ovr_drain");
        read_en = 1'b1;
        @(posedge clk_rx);
        #1 read_en = 1'b0;
        @(negedge clk_rx);
        check("empty_read_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check("empty_read_full", {31'd0, rx_fifo_full}, 32'd0);
        send_frame(8'h3A, 1'b1);
        exp_q.push_back(8'h3A);
        idle(20);
        drain("after_empty_read");

        // Reset during data bit 4 with one byte queued
        send_frame(8'h11, 1'b1);
        idle(20);
        @(negedge clk_rx);
        check("mid_queued", {31'd0, rx_fifo_empty}, 32'd0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'hC3 >> i) & 8'h01));
        rxd_rx = 1'b0;
        repeat (BIT / 2) @(posedge clk_rx);
        #1 rst_n_clk_rx = 1'b0;
        #1;
        check("mid_rst_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check("mid_rst_full", {31'd0, rx_fifo_full}, 32'd0);
        check("mid_rst_dout", {24'd0, rx_dout}, 32'h00);
        check("mid_rst_pulses", {30'd0, frm_err, overrun}, 32'd0);
        rxd_rx = 1'b1;
        repeat (5) @(posedge clk_rx);
        #1 rst_n_clk_rx = 1'b1;
        idle(2 * BIT);
        send_frame(8'h96, 1'b1);
        exp_q.push_back(8'h96);
        idle(20);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
